// File: rtl/aes_pkg.sv
// Shared AES byte-substitution definitions: FIPS-197 forward/inverse S-boxes,
// engine state encoding and a single-byte lookup helper.
`timescale 1ns/1ps
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Entry 0 sits in the most significant byte so the literal reads like the
  // published table, row by row.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Substitute one byte through the forward or inverse table.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
    int idx;
    idx = 2047 - 8 * int'(b);
    if (inv) begin
      return SBOX_INV[idx -: 8];
    end
    return SBOX_FWD[idx -: 8];
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational byte substitution unit with forward/inverse select.
`timescale 1ns/1ps
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_inv,
  output logic [7:0] o_byte
);

  assign o_byte = sbox_lookup(i_byte, i_inv);

endmodule

// File: rtl/sbox_sub_engine.sv
// Time-multiplexed SubBytes/InvSubBytes engine: LANES substitution units walk
// over a BYTES-wide working register, LANES bytes per cycle, then hold the
// result until the consumer takes it.
`timescale 1ns/1ps
module sbox_sub_engine
  import aes_pkg::*;
#(
  parameter int BYTES = 16,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*BYTES-1:0] out_data,
  output logic               busy
);

  localparam int N  = BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int W  = 8 * BYTES;

  // Refuse to build an engine whose lanes do not tile the word exactly.
  generate
    if ((BYTES % LANES) != 0) begin : g_bad_lanes
      $error("sbox_sub_engine: LANES must divide BYTES exactly");
    end
  endgenerate

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [W-1:0]    r_work;
  logic [W-1:0]    w_work_next;
  logic            r_inv;
  logic            w_inv_next;
  logic [7:0]      w_lane_in  [LANES];
  logic [7:0]      w_lane_out [LANES];

  // Lane gi always works on byte (step*LANES + gi) of the working register.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_in[gi] = r_work[(int'(r_cnt) * LANES + gi) * 8 +: 8];

      sbox_lane u_lane (
        .i_byte (w_lane_in[gi]),
        .i_inv  (r_inv),
        .o_byte (w_lane_out[gi])
      );
    end
  endgenerate

  // Result comes straight from the working register, never from in_data.
  assign out_data = r_work;

  // Next-state, handshake outputs and write-back of the active lane slice.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_work_next  = r_work;
    w_inv_next   = r_inv;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_work_next  = in_data;
          w_inv_next   = in_inv;
          w_cnt_next   = '0;
          w_state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        busy = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          w_work_next[(int'(r_cnt) * LANES + l) * 8 +: 8] = w_lane_out[l];
        end
        if (r_cnt == CW'(N - 1)) begin
          w_cnt_next   = '0;
          w_state_next = ST_DONE;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        // Accepting a new word while the result leaves avoids an idle bubble.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_work_next  = in_data;
            w_inv_next   = in_inv;
            w_cnt_next   = '0;
            w_state_next = ST_RUN;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, step counter, working word and latched mode; reset drops any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_work  <= w_work_next;
      r_inv   <= w_inv_next;
    end
  end

endmodule

// File: tb/tb_sbox_sub_engine.sv
// Directed-vector bench for sbox_sub_engine: a 16/4 engine plus 4/1 and 4/4
// variants for the parameter sweep.
`timescale 1ns/1ps
module tb_sbox_sub_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;

  // Main engine, BYTES=16 LANES=4
  logic         in_valid, in_inv, out_ready;
  logic [127:0] in_data;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;

  // BYTES=4 LANES=1
  logic         a_in_valid, a_in_inv, a_out_ready;
  logic [31:0]  a_in_data;
  logic         a_in_ready, a_out_valid, a_busy;
  logic [31:0]  a_out_data;

  // BYTES=4 LANES=4
  logic         b_in_valid, b_in_inv, b_out_ready;
  logic [31:0]  b_in_data;
  logic         b_in_ready, b_out_valid, b_busy;
  logic [31:0]  b_out_data;

  sbox_sub_engine #(.BYTES(16), .LANES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  sbox_sub_engine #(.BYTES(4), .LANES(1)) dut_4x1 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_inv(a_in_inv),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
  );

  sbox_sub_engine #(.BYTES(4), .LANES(4)) dut_4x4 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_inv(b_in_inv),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] APPB_IN  = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
  localparam logic [127:0] APPB_OUT = 128'hD42711AEE0BF98F1B8B45DE51E415230;

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full transaction on the main engine; inputs are scrambled during RUN.
  task automatic run_txn(input logic [127:0] d, input logic inv,
                         output logic [127:0] res, output int lat);
    @(negedge clk);
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_inv   = ~inv;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = out_data;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Full forward transaction on one of the 4-byte engines.
  task automatic run_small(input bit wide_lanes, input logic [31:0] d,
                           output logic [31:0] res, output int lat);
    @(negedge clk);
    if (wide_lanes) begin
      b_in_valid = 1'b1; b_in_data = d; b_in_inv = 1'b0;
    end else begin
      a_in_valid = 1'b1; a_in_data = d; a_in_inv = 1'b0;
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    lat = 0;
    while (!(wide_lanes ? b_out_valid : a_out_valid) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = wide_lanes ? b_out_data : a_out_data;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res;
    logic [31:0]  sres;
    int           lat;

    vecs[0] = '{128'h0,                      1'b0, {16{8'h63}}};
    vecs[1] = '{{120'h0, 8'h53},             1'b0, {{15{8'h63}}, 8'hED}};
    vecs[2] = '{{120'h0, 8'hFF},             1'b0, {{15{8'h63}}, 8'h16}};
    vecs[3] = '{APPB_IN,                     1'b0, APPB_OUT};
    vecs[4] = '{APPB_OUT,                    1'b1, APPB_IN};
    vecs[5] = '{{16{8'h63}},                 1'b1, 128'h0};
    vecs[6] = '{{{15{8'h63}}, 8'hED},        1'b1, {120'h0, 8'h53}};
    vecs[7] = '{{{15{8'h63}}, 8'h16},        1'b1, {120'h0, 8'hFF}};
    vecs[8] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0,
                128'h637c777bf26b6fc53001672bfed7ab76};

    rst = 1'b1;
    in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_data = '0;
    a_in_valid = 1'b0; a_in_inv = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    b_in_valid = 1'b0; b_in_inv = 1'b0; b_out_ready = 1'b0; b_in_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy",      128'(busy),      128'd0);
    chk("rst_out_data",  out_data,        128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready",  128'(in_ready),  128'd1);

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].din, vecs[i].inv, res, lat);
      $display("txn vec%0d in=%h inv=%b out=%h lat=%0d", i, vecs[i].din, vecs[i].inv, res, lat);
      chk($sformatf("vec%0d_data", i), res, vecs[i].dout);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
    end

    // Backpressure in DONE with in_inv toggling during RUN
    @(negedge clk);
    in_valid = 1'b1; in_data = APPB_IN; in_inv = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_busy_in_run", 128'(busy), 128'd1);
      in_inv  = ~in_inv;
      in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk);
      #1;
    end
    chk("bp_valid_at_4", 128'(out_valid), 128'd1);
    chk("bp_toggle_inv_data", out_data, APPB_OUT);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 128'(out_valid), 128'd1);
      chk("bp_hold_data",  out_data,        APPB_OUT);
      chk("bp_in_ready",   128'(in_ready),  128'd0);
    end
    $display("txn backpressure in=%h out=%h held 5 cycles", APPB_IN, out_data);

    // Back-to-back accept in the same cycle the result leaves
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 128'h0; in_inv = 1'b0;
    #1;
    chk("b2b_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '1;
    chk("b2b_valid_drop", 128'(out_valid), 128'd0);
    chk("b2b_busy",       128'(busy),      128'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("txn back_to_back in=%h out=%h lat=%0d", 128'h0, out_data, lat);
    chk("b2b_latency", 128'(lat), 128'd4);
    chk("b2b_data",    out_data,  {16{8'h63}});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drain_to_idle", 128'(in_ready), 128'd1);

    // Reset asserted at step 2 of a transaction
    @(negedge clk);
    in_valid = 1'b1; in_data = {16{8'h53}}; in_inv = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_busy",      128'(busy),      128'd0);
    chk("midrst_out_data",  out_data,        128'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_after", 128'(in_ready), 128'd1);
    chk("midrst_busy_after",     128'(busy),     128'd0);
    run_txn(128'h0, 1'b0, res, lat);
    $display("txn after_reset in=%h out=%h lat=%0d", 128'h0, res, lat);
    chk("midrst_next_data",    res,       {16{8'h63}});
    chk("midrst_next_latency", 128'(lat), 128'd4);

    // Parameter sweep
    run_small(1'b0, 32'h00010203, sres, lat);
    $display("txn bytes4_lanes1 in=%h out=%h lat=%0d", 32'h00010203, sres, lat);
    chk("4x1_data",    128'(sres), 128'h637C777B);
    chk("4x1_latency", 128'(lat),  128'd4);
    run_small(1'b1, 32'h00010203, sres, lat);
    $display("txn bytes4_lanes4 in=%h out=%h lat=%0d", 32'h00010203, sres, lat);
    chk("4x4_data",    128'(sres), 128'h637C777B);
    chk("4x4_latency", 128'(lat),  128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
